// File: rtl/ysyx_25040129_axil_sram_slave_if.sv
// AXI4-Lite bus bundle between a master and the SRAM responder.
interface ysyx_25040129_axil_sram_slave_if;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arsize, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arsize, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_25040129_axil_sram_slave.sv
// AXI4-Lite responder backed by a word-organised SRAM array.
// Independent read and write FSMs, each with a configurable response latency.
// Optional macro RAND_DELAY_EN: LFSR-driven extra latency and address-ready throttling.
module ysyx_25040129_axil_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LAT         = 1
) (
  input  logic clk,
  input  logic rst,
  ysyx_25040129_axil_sram_slave_if.slave s_axi
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 5;
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_e;
  typedef enum logic [2:0] {W_IDLE = 3'd0, W_AW = 3'd1, W_W = 3'd2, W_WAIT = 3'd3, W_RESP = 3'd4} w_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;

  logic [31:0] mem_q [DEPTH_WORDS];

  r_state_e          r_state_q, r_state_d;
  logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
  logic [31:0]       r_addr_q, r_addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  w_state_e          w_state_q, w_state_d;
  logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
  wr_req_t           w_req_q, w_req_d;
  logic [1:0]        bresp_q, bresp_d;

  logic              addr_block_c;
  logic [CNT_W-1:0]  extra_c;
  logic [CNT_W-1:0]  delay_c;
  logic              arready_c, awready_c, wready_c;
  logic              ar_hs_c, aw_hs_c, w_hs_c;
  logic [31:0]       r_addr_eff_c, r_off_c;
  logic              r_in_range_c, r_enter_c;
  wr_req_t           w_eff_c;
  logic [31:0]       w_off_c;
  logic              w_in_range_c, w_start_c, w_enter_c, w_commit_c;
  logic              unused_c;

`ifdef RAND_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4, free-running.
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // LFSR register.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end

  assign addr_block_c = lfsr_q[7];
  assign extra_c      = CNT_W'(lfsr_q[1:0]);
`else
  assign addr_block_c = 1'b0;
  assign extra_c      = '0;
`endif

  assign delay_c   = CNT_W'(LAT) + extra_c;
  assign unused_c  = ^s_axi.arsize;

  // Readies decode purely from FSM state (and the throttle LFSR).
  assign arready_c = (r_state_q == R_IDLE) && !addr_block_c;
  assign awready_c = ((w_state_q == W_IDLE) || (w_state_q == W_W)) && !addr_block_c;
  assign wready_c  = (w_state_q == W_IDLE) || (w_state_q == W_AW);

  assign ar_hs_c = s_axi.arvalid && arready_c;
  assign aw_hs_c = s_axi.awvalid && awready_c;
  assign w_hs_c  = s_axi.wvalid && wready_c;

  assign s_axi.arready = arready_c;
  assign s_axi.awready = awready_c;
  assign s_axi.wready  = wready_c;
  assign s_axi.rvalid  = (r_state_q == R_RESP);
  assign s_axi.bvalid  = (w_state_q == W_RESP);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.bresp   = bresp_q;

  // Read address seen by the array: live bus on acceptance, latched copy while waiting.
  assign r_addr_eff_c = (r_state_q == R_IDLE) ? s_axi.araddr : r_addr_q;
  assign r_off_c      = r_addr_eff_c - ADDR_BASE;
  assign r_in_range_c = r_off_c < SPAN;

  // Write payload seen by the array: whichever half arrives this cycle bypasses the latch.
  always_comb begin
    w_eff_c      = w_req_q;
    if (aw_hs_c) w_eff_c.addr = s_axi.awaddr;
    if (w_hs_c) begin
      w_eff_c.data = s_axi.wdata;
      w_eff_c.strb = s_axi.wstrb;
    end
  end

  assign w_off_c      = w_eff_c.addr - ADDR_BASE;
  assign w_in_range_c = w_off_c < SPAN;
  assign w_commit_c   = w_enter_c && w_in_range_c && !rst;

  // Read FSM next-state and response capture.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_addr_d  = r_addr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_enter_c = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          r_addr_d = s_axi.araddr;
          if (delay_c == '0) begin
            r_enter_c = 1'b1;
          end else begin
            r_state_d = R_WAIT;
            r_cnt_d   = delay_c;
          end
        end
      end
      R_WAIT: begin
        r_cnt_d = r_cnt_q - CNT_W'(1);
        if (r_cnt_q == CNT_W'(1)) r_enter_c = 1'b1;
      end
      R_RESP: begin
        if (s_axi.rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_enter_c) begin
      r_state_d = R_RESP;
      rdata_d   = r_in_range_c ? mem_q[r_off_c[IDX_W+1:2]] : 32'h0;
      rresp_d   = r_in_range_c ? RESP_OKAY : RESP_DECERR;
    end
  end

  // Write FSM next-state, payload latching and response capture.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    w_req_d   = w_req_q;
    bresp_d   = bresp_q;
    w_start_c = 1'b0;
    w_enter_c = 1'b0;
    if (aw_hs_c) w_req_d.addr = s_axi.awaddr;
    if (w_hs_c) begin
      w_req_d.data = s_axi.wdata;
      w_req_d.strb = s_axi.wstrb;
    end
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) w_start_c = 1'b1;
        else if (aw_hs_c)      w_state_d = W_AW;
        else if (w_hs_c)       w_state_d = W_W;
      end
      W_AW: begin
        if (w_hs_c) w_start_c = 1'b1;
      end
      W_W: begin
        if (aw_hs_c) w_start_c = 1'b1;
      end
      W_WAIT: begin
        w_cnt_d = w_cnt_q - CNT_W'(1);
        if (w_cnt_q == CNT_W'(1)) w_enter_c = 1'b1;
      end
      W_RESP: begin
        if (s_axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (w_start_c) begin
      if (delay_c == '0) begin
        w_enter_c = 1'b1;
      end else begin
        w_state_d = W_WAIT;
        w_cnt_d   = delay_c;
      end
    end
    if (w_enter_c) begin
      w_state_d = W_RESP;
      bresp_d   = w_in_range_c ? RESP_OKAY : RESP_DECERR;
    end
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_addr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      w_req_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_addr_q  <= r_addr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      w_req_q   <= w_req_d;
      bresp_q   <= bresp_d;
    end
  end

  // Array write with per-byte enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit_c) begin
      for (int b = 0; b < 4; b++) begin
        if (w_eff_c.strb[b]) mem_q[w_off_c[IDX_W+1:2]][8*b +: 8] <= w_eff_c.data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_axil_sram_slave.sv
// Randomised bench for the AXI4-Lite SRAM responder with a cycle-level reference model.
module tb_ysyx_25040129_axil_sram_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_25040129_axil_sram_slave_if axi();

  ysyx_25040129_axil_sram_slave #(
    .ADDR_BASE  (BASE),
    .DEPTH_WORDS(DEPTH),
    .LAT        (LAT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .s_axi(axi)
  );

  int checks   = 0;
  int failures = 0;
  int rr_mode  = 0;  // 0: ready high, 1: random, 2: ready low

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL timeout %s at t=%0t", name, $time);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(DEPTH * 4);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  function automatic logic [31:0] init_val(input int i);
    return 32'hA5C3_0000 ^ (32'(i) * 32'h0103_0507);
  endfunction

  // Response-channel ready drivers, changed well clear of both edges.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rr_mode)
        0:       begin axi.rready = 1'b1; axi.bready = 1'b1; end
        1:       begin axi.rready = ($urandom_range(0, 3) != 0); axi.bready = ($urandom_range(0, 3) != 0); end
        default: begin axi.rready = 1'b0; axi.bready = 1'b1; end
      endcase
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] mdl_mem [int];
  bit          m_ok = 1'b0;
  int          cyc  = 0;
  bit          rd_busy, r_out, r_known;
  logic [31:0] r_addr, r_data;
  logic [1:0]  r_resp;
  int          r_due;
  bit          aw_held, w_held, w_pend, b_out;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  b_resp;
  int          w_due;

  // Compare DUT against model, then advance model across the coming edge.
  always @(negedge clk) begin
    bit ar_hs, aw_hs, w_hs, r_hs, b_hs;
    if (m_ok) begin
      chk("arready", 32'(axi.arready), 32'(!rd_busy));
      chk("awready", 32'(axi.awready), 32'(!aw_held));
      chk("wready",  32'(axi.wready),  32'(!w_held));
      chk("rvalid",  32'(axi.rvalid),  32'(r_out));
      chk("bvalid",  32'(axi.bvalid),  32'(b_out));
      if (r_out) begin
        chk("rresp", 32'(axi.rresp), 32'(r_resp));
        if (r_known) chk("rdata", axi.rdata, r_data);
      end
      if (b_out) chk("bresp", 32'(axi.bresp), 32'(b_resp));
    end
    if (rst) begin
      rd_busy = 0; r_out = 0; aw_held = 0; w_held = 0; w_pend = 0; b_out = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      ar_hs = axi.arvalid && !rd_busy;
      aw_hs = axi.awvalid && !aw_held;
      w_hs  = axi.wvalid && !w_held;
      r_hs  = r_out && axi.rready;
      b_hs  = b_out && axi.bready;
      if (r_hs) begin r_out = 0; rd_busy = 0; end
      if (b_hs) begin b_out = 0; aw_held = 0; w_held = 0; end
      if (ar_hs) begin rd_busy = 1; r_addr = axi.araddr; r_due = cyc + int'(LAT); end
      if (aw_hs) begin aw_held = 1; m_awaddr = axi.awaddr; end
      if (w_hs) begin w_held = 1; m_wdata = axi.wdata; m_wstrb = axi.wstrb; end
      if ((aw_hs || w_hs) && aw_held && w_held) begin w_pend = 1; w_due = cyc + int'(LAT); end
      // Reads sample the array before any write landing on the same edge.
      if (rd_busy && !r_out && r_due == cyc) begin
        r_out = 1;
        if (in_rng(r_addr)) begin
          r_resp  = 2'b00;
          r_known = mdl_mem.exists(widx(r_addr));
          r_data  = r_known ? mdl_mem[widx(r_addr)] : 32'h0;
        end else begin
          r_resp  = 2'b11;
          r_known = 1;
          r_data  = 32'h0;
        end
      end
      if (w_pend && w_due == cyc) begin
        w_pend = 0;
        b_out  = 1;
        if (in_rng(m_awaddr)) begin
          logic [31:0] wd;
          b_resp = 2'b00;
          wd = mdl_mem.exists(widx(m_awaddr)) ? mdl_mem[widx(m_awaddr)] : 32'h0;
          for (int b = 0; b < 4; b++) if (m_wstrb[b]) wd[8*b +: 8] = m_wdata[8*b +: 8];
          mdl_mem[widx(m_awaddr)] = wd;
        end else begin
          b_resp = 2'b11;
        end
      end
    end
    cyc++;
  end

  // ---------------- bus master tasks (enter and leave at posedge+1) ----------------
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r, output int lat);
    int t;
    axi.araddr  = a;
    axi.arsize  = 3'd2;
    axi.arvalid = 1'b1;
    t = 0;
    d = 32'h0; r = 2'b00; lat = 0;
    forever begin
      @(negedge clk);
      if (axi.arready) break;
      t++;
      if (t > 200) begin timeout("arready"); axi.arvalid = 1'b0; return; end
    end
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (axi.rvalid) break;
      lat++;
      if (lat > 200) begin timeout("rvalid"); return; end
    end
    d = axi.rdata;
    r = axi.rresp;
    t = 0;
    while (!axi.rready) begin
      @(negedge clk);
      t++;
      if (t > 200) begin timeout("rready"); return; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input bit wait_b, output logic [1:0] br, output int lat);
    bit aw_done, w_done;
    int t, aw_start, w_start;
    aw_done = 0; w_done = 0; t = 0;
    br = 2'b00; lat = 0;
    aw_start = (lead < 0) ? -lead : 0;
    w_start  = (lead > 0) ? lead : 0;
    forever begin
      axi.awaddr  = a;
      axi.wdata   = d;
      axi.wstrb   = s;
      axi.awvalid = !aw_done && (t >= aw_start);
      axi.wvalid  = !w_done && (t >= w_start);
      @(negedge clk);
      if (axi.awvalid && axi.awready) aw_done = 1;
      if (axi.wvalid && axi.wready) w_done = 1;
      @(posedge clk); #1;
      t++;
      if (aw_done && w_done) break;
      if (t > 200) begin timeout("aw/w"); break; end
    end
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    if (!wait_b || !(aw_done && w_done)) return;
    lat = 1;
    forever begin
      @(negedge clk);
      if (axi.bvalid) break;
      lat++;
      if (lat > 200) begin timeout("bvalid"); return; end
    end
    br = axi.bresp;
    t = 0;
    while (!axi.bready) begin
      @(negedge clk);
      t++;
      if (t > 200) begin timeout("bready"); return; end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_addr(input int words);
    if ($urandom_range(0, 15) == 0) return 32'($urandom);
    return BASE + 32'(4 * $urandom_range(0, words - 1)) + 32'($urandom_range(0, 3));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          l;
    axi.araddr = '0; axi.arsize = '0; axi.arvalid = 1'b0;
    axi.awaddr = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.rready = 1'b0; axi.bready = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rvalid",  32'(axi.rvalid),  32'd0);
    chk("rst_bvalid",  32'(axi.bvalid),  32'd0);
    chk("rst_arready", 32'(axi.arready), 32'd1);
    chk("rst_awready", 32'(axi.awready), 32'd1);
    chk("rst_wready",  32'(axi.wready),  32'd1);
    chk("rst_rresp",   32'(axi.rresp),   32'd0);
    chk("rst_bresp",   32'(axi.bresp),   32'd0);
    chk("rst_rdata",   axi.rdata,        32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 32; i++) do_write(BASE + 32'(4 * i), init_val(i), 4'hF, 0, 1'b1, r, l);

    // Full-word write then read back, latency 1+LAT each way.
    do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b1, r, l);
    chk("wr_bresp", 32'(r), 32'd0);
    chk("wr_lat",   32'(l), 32'd2);
    do_read(BASE + 32'h10, d, r, l);
    chk("rd_data", d, 32'hDEAD_BEEF);
    chk("rd_resp", 32'(r), 32'd0);
    chk("rd_lat",  32'(l), 32'd2);

    // Single-byte merge.
    do_write(BASE + 32'h14, 32'h1122_3344, 4'hF, 0, 1'b1, r, l);
    do_write(BASE + 32'h14, 32'h0000_AB00, 4'b0010, 0, 1'b1, r, l);
    do_read(BASE + 32'h14, d, r, l);
    chk("byte_merge", d, 32'h1122_AB44);

    // Address leads data by 3 cycles, then data leads address by 2.
    do_write(BASE + 32'h18, 32'hCAFE_F00D, 4'hF, 3, 1'b1, r, l);
    chk("awlead_lat",   32'(l), 32'd2);
    chk("awlead_bresp", 32'(r), 32'd0);
    do_read(BASE + 32'h18, d, r, l);
    chk("awlead_data", d, 32'hCAFE_F00D);
    do_write(BASE + 32'h1C, 32'h0F1E_2D3C, 4'hF, -2, 1'b1, r, l);
    do_read(BASE + 32'h1C, d, r, l);
    chk("wlead_data", d, 32'h0F1E_2D3C);

    // Out-of-range accesses.
    do_read(32'h7FFF_FFFC, d, r, l);
    chk("oor_rresp", 32'(r), 32'd3);
    chk("oor_rdata", d, 32'h0);
    do_write(BASE + 32'(DEPTH * 4), 32'h5555_5555, 4'hF, 0, 1'b1, r, l);
    chk("oor_bresp", 32'(r), 32'd3);
    do_read(BASE, d, r, l);
    chk("oor_untouched", d, init_val(0));

    // Read response held under back-pressure.
    rr_mode = 2;
    @(posedge clk); #1;
    axi.araddr = BASE + 32'h10; axi.arvalid = 1'b1;
    @(negedge clk);
    chk("hold_accept", 32'(axi.arready), 32'd1);
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_arready", 32'(axi.arready), 32'd0);
    chk("hold_rvalid",  32'(axi.rvalid),  32'd1);
    chk("hold_rdata",   axi.rdata,        32'hDEAD_BEEF);
    rr_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset while the write is waiting: nothing committed, no response.
    do_write(BASE + 32'h10, 32'h0BAD_F00D, 4'hF, 0, 1'b0, r, l);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_bvalid",  32'(axi.bvalid),  32'd0);
    chk("abort_arready", 32'(axi.arready), 32'd1);
    chk("abort_awready", 32'(axi.awready), 32'd1);
    chk("abort_wready",  32'(axi.wready),  32'd1);
    @(posedge clk); #1;
    do_read(BASE + 32'h10, d, r, l);
    chk("abort_data", d, 32'hDEAD_BEEF);

    // Concurrent randomised traffic over a small window to force collisions.
    rr_mode = 1;
    fork
      begin
        logic [31:0] rd;
        logic [1:0]  rr;
        int          rl;
        repeat (150) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          do_read(rnd_addr(8), rd, rr, rl);
        end
      end
      begin
        logic [1:0] wr;
        int         wl;
        repeat (150) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          do_write(rnd_addr(8), 32'($urandom), 4'($urandom_range(0, 15)),
                   $urandom_range(0, 6) - 3, 1'b1, wr, wl);
        end
      end
    join
    rr_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
